easyaxi_rd_mst_ost: RTL and testbench

AXI4 read master with up to OST_DEPTH outstanding bursts, the parametrised successor of the single-transaction EasyAXI read master. Each `enable` pulse allocates a tracking entry. Entries issue AR requests in allocation order and retire independently when their RLAST arrives, in any ID order. The block sits at the master side of the EasyAXI test fabric and reports per-transaction completion and error status to the bench.

---
 rtl/easyaxi_rd_mst_ost.sv | 175 +++++++++++++++++
 tb/tb_easyaxi_rd_mst_ost.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/easyaxi_rd_mst_ost.sv
// AXI4 read master with OST_DEPTH outstanding bursts.
// Bursts issue in allocation order and retire out of order on RLAST.
module easyaxi_rd_mst_ost #(
  parameter int unsigned OST_DEPTH = 4,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_LEN = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  output logic                       axi_mst_arvalid,
  input  logic                       axi_mst_arready,
  output logic [ID_W-1:0]            axi_mst_arid,
  output logic [ADDR_W-1:0]          axi_mst_araddr,
  output logic [7:0]                 axi_mst_arlen,
  output logic [2:0]                 axi_mst_arsize,
  output logic [1:0]                 axi_mst_arburst,
  input  logic                       axi_mst_rvalid,
  output logic                       axi_mst_rready,
  input  logic [ID_W-1:0]            axi_mst_rid,
  input  logic [DATA_W-1:0]          axi_mst_rdata,
  input  logic [1:0]                 axi_mst_rresp,
  input  logic                       axi_mst_rlast,
  output logic                       full,
  output logic [$clog2(OST_DEPTH):0] ost_cnt,
  output logic                       done_vld,
  output logic [ID_W-1:0]            done_id,
  output logic                       done_err,
  output logic [DATA_W-1:0]          last_rdata,
  output logic                       proto_err
);

  localparam int unsigned IDX_W    = $clog2(OST_DEPTH);
  localparam int unsigned CNT_W    = IDX_W + 1;
  localparam int unsigned ADDR_INC = (BURST_LEN + 1) * (DATA_W / 8);

  logic [OST_DEPTH-1:0]            vld_q, vld_d, req_q, req_d, err_q, err_d;
  logic [OST_DEPTH-1:0][7:0]       beats_q, beats_d;
  logic [OST_DEPTH-1:0][IDX_W-1:0] fifo_q, fifo_d;
  logic [IDX_W-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                fifo_cnt_q, fifo_cnt_d;
  logic [ADDR_W-1:0]               addr_q, addr_d;
  logic                            done_vld_q, done_vld_d;
  logic [ID_W-1:0]                 done_id_q, done_id_d;
  logic                            done_err_q, done_err_d;
  logic [DATA_W-1:0]               last_rdata_q, last_rdata_d;
  logic                            proto_err_q, proto_err_d;

  logic [IDX_W-1:0] free_idx, head_idx, rid_idx;
  logic [CNT_W-1:0] pop_cnt;
  logic             alloc, ar_hs, r_hs, r_match, len_err, beat_err;

  // Lowest-index free entry; entries retiring this edge still read as busy
  always_comb begin
    free_idx = '0;
    for (int i = OST_DEPTH - 1; i >= 0; i--) begin
      if (!vld_q[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < OST_DEPTH; i++) pop_cnt = pop_cnt + CNT_W'(vld_q[i]);
  end

  assign full     = (pop_cnt == CNT_W'(OST_DEPTH));
  assign ost_cnt  = pop_cnt;
  assign alloc    = enable & ~full;
  assign head_idx = fifo_q[rd_ptr_q];
  assign ar_hs    = axi_mst_arvalid & axi_mst_arready;
  assign r_hs     = axi_mst_rvalid & axi_mst_rready;
  assign rid_idx  = axi_mst_rid[IDX_W-1:0];
  assign r_match  = (32'(axi_mst_rid) < OST_DEPTH) && vld_q[rid_idx] && req_q[rid_idx];
  assign len_err  = ( axi_mst_rlast && (beats_q[rid_idx] != 8'(BURST_LEN))) ||
                    (!axi_mst_rlast && (beats_q[rid_idx] == 8'(BURST_LEN)));
  assign beat_err = (axi_mst_rresp != 2'b00) | len_err;

  // Allocation, AR issue and R retire touch disjoint entries, so they compose freely
  always_comb begin
    vld_d        = vld_q;
    req_d        = req_q;
    err_d        = err_q;
    beats_d      = beats_q;
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    addr_d       = addr_q;
    done_vld_d   = 1'b0;
    done_id_d    = done_id_q;
    done_err_d   = done_err_q;
    last_rdata_d = last_rdata_q;
    proto_err_d  = proto_err_q;
    if (alloc) begin
      vld_d[free_idx]   = 1'b1;
      req_d[free_idx]   = 1'b0;
      err_d[free_idx]   = 1'b0;
      beats_d[free_idx] = 8'd0;
      fifo_d[wr_ptr_q]  = free_idx;
      wr_ptr_d          = wr_ptr_q + IDX_W'(1);
    end
    if (ar_hs) begin
      req_d[head_idx] = 1'b1;
      rd_ptr_d        = rd_ptr_q + IDX_W'(1);
      addr_d          = addr_q + ADDR_W'(ADDR_INC);
    end
    fifo_cnt_d = fifo_cnt_q + CNT_W'(alloc) - CNT_W'(ar_hs);
    if (r_hs) begin
      last_rdata_d = axi_mst_rdata;
      if (r_match) begin
        beats_d[rid_idx] = beats_q[rid_idx] + 8'd1;
        err_d[rid_idx]   = err_q[rid_idx] | beat_err;
        if (len_err) proto_err_d = 1'b1;
        if (axi_mst_rlast) begin
          vld_d[rid_idx] = 1'b0;
          req_d[rid_idx] = 1'b0;
          done_vld_d     = 1'b1;
          done_id_d      = axi_mst_rid;
          done_err_d     = err_q[rid_idx] | beat_err;
        end
      end else begin
        proto_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q        <= '0;
      req_q        <= '0;
      err_q        <= '0;
      beats_q      <= '0;
      fifo_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      addr_q       <= '0;
      done_vld_q   <= 1'b0;
      done_id_q    <= '0;
      done_err_q   <= 1'b0;
      last_rdata_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      vld_q        <= vld_d;
      req_q        <= req_d;
      err_q        <= err_d;
      beats_q      <= beats_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      addr_q       <= addr_d;
      done_vld_q   <= done_vld_d;
      done_id_q    <= done_id_d;
      done_err_q   <= done_err_d;
      last_rdata_q <= last_rdata_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign axi_mst_arvalid = (fifo_cnt_q != '0);
  assign axi_mst_arid    = ID_W'(head_idx);
  assign axi_mst_araddr  = addr_q;
  assign axi_mst_arlen   = 8'(BURST_LEN);
  assign axi_mst_arsize  = 3'($clog2(DATA_W / 8));
  assign axi_mst_arburst = 2'b01;
  assign axi_mst_rready  = ~rst;
  assign done_vld        = done_vld_q;
  assign done_id         = done_id_q;
  assign done_err        = done_err_q;
  assign last_rdata      = last_rdata_q;
  assign proto_err       = proto_err_q;

endmodule

// File: tb/tb_easyaxi_rd_mst_ost.sv
// Directed bench for easyaxi_rd_mst_ost at default parameters
// (4 entries, 4-beat bursts, 32-bit data, 16-byte address stride).
module tb_easyaxi_rd_mst_ost;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        arvalid, arready = 1'b0;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid = 1'b0, rready;
  logic [3:0]  rid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        full;
  logic [2:0]  ost_cnt;
  logic        done_vld, done_err, proto_err;
  logic [3:0]  done_id;
  logic [31:0] last_rdata;

  int n_chk = 0;
  int n_fail = 0;

  easyaxi_rd_mst_ost dut (
    .clk(clk), .rst(rst), .enable(enable),
    .axi_mst_arvalid(arvalid), .axi_mst_arready(arready), .axi_mst_arid(arid),
    .axi_mst_araddr(araddr), .axi_mst_arlen(arlen), .axi_mst_arsize(arsize),
    .axi_mst_arburst(arburst), .axi_mst_rvalid(rvalid), .axi_mst_rready(rready),
    .axi_mst_rid(rid), .axi_mst_rdata(rdata), .axi_mst_rresp(rresp),
    .axi_mst_rlast(rlast), .full(full), .ost_cnt(ost_cnt), .done_vld(done_vld),
    .done_id(done_id), .done_err(done_err), .last_rdata(last_rdata),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Returns one burst on id; err_beat gets SLVERR, rlast on last_beat
  task automatic r_burst(input logic [3:0] id, input logic [31:0] base, input int err_beat,
                         input int last_beat, input logic exp_err, input logic exp_perr);
    for (int b = 0; b <= last_beat; b++) begin
      rvalid = 1'b1;
      rid    = id;
      rdata  = base + 32'(b);
      rresp  = (b == err_beat) ? 2'b10 : 2'b00;
      rlast  = (b == last_beat);
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    chk("done_vld", done_vld, 1);
    chk("done_id", done_id, id);
    chk("done_err", done_err, exp_err);
    chk("last_rdata", last_rdata, base + 32'(last_beat));
    chk("proto_err", proto_err, exp_perr);
  endtask

  initial begin
    tick();
    // Reset values
    chk("rst arvalid", arvalid, 0);
    chk("rst arid", arid, 0);
    chk("rst araddr", araddr, 0);
    chk("rst rready", rready, 0);
    chk("rst full", full, 0);
    chk("rst ost_cnt", ost_cnt, 0);
    chk("rst done_vld", done_vld, 0);
    chk("rst done_id", done_id, 0);
    chk("rst done_err", done_err, 0);
    chk("rst last_rdata", last_rdata, 0);
    chk("rst proto_err", proto_err, 0);
    chk("arlen", arlen, 3);
    chk("arsize", arsize, 2);
    chk("arburst", arburst, 1);
    rst = 1'b0;
    #1;
    chk("rready", rready, 1);

    // Single burst
    enable = 1'b1;
    tick();
    enable = 1'b0;
    chk("t1 arvalid", arvalid, 1);
    chk("t1 arid", arid, 0);
    chk("t1 araddr", araddr, 0);
    chk("t1 ost_cnt", ost_cnt, 1);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("t1 arvalid after hs", arvalid, 0);
    chk("t1 araddr next", araddr, 32'h10);
    r_burst(4'd0, 32'h100, 4, 3, 1'b0, 1'b0);
    chk("t1 ost_cnt end", ost_cnt, 0);
    tick();
    chk("t1 done pulse width", done_vld, 0);

    // Fill and overflow
    do_reset();
    arready = 1'b1;
    enable  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fill arid", arid, 64'(i));
      chk("fill araddr", araddr, 64'(16 * i));
      chk("fill ost_cnt", ost_cnt, 64'(i + 1));
      chk("fill full", full, (i == 3) ? 64'd1 : 64'd0);
    end
    tick();
    enable  = 1'b0;
    arready = 1'b0;
    chk("ovf ost_cnt", ost_cnt, 4);
    chk("ovf arvalid", arvalid, 0);
    chk("ovf full", full, 1);
    chk("ovf araddr", araddr, 32'h40);

    // Out-of-order return
    do_reset();
    arready = 1'b1;
    enable  = 1'b1;
    repeat (3) tick();
    enable = 1'b0;
    tick();
    arready = 1'b0;
    chk("ooo ost_cnt", ost_cnt, 3);
    chk("ooo arvalid", arvalid, 0);
    r_burst(4'd2, 32'h200, 4, 3, 1'b0, 1'b0);
    chk("ooo ost_cnt after 2", ost_cnt, 2);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    chk("ooo realloc arid", arid, 2);
    chk("ooo realloc araddr", araddr, 32'h30);
    chk("ooo realloc ost_cnt", ost_cnt, 3);
    r_burst(4'd0, 32'h300, 4, 3, 1'b0, 1'b0);
    r_burst(4'd1, 32'h400, 4, 3, 1'b0, 1'b0);
    chk("ooo ost_cnt tail", ost_cnt, 1);

    // AR back-pressure
    do_reset();
    enable = 1'b1;
    repeat (2) tick();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp arvalid", arvalid, 1);
      chk("bp arid", arid, 0);
      chk("bp araddr", araddr, 0);
      tick();
    end
    arready = 1'b1;
    tick();
    chk("bp arid 1", arid, 1);
    chk("bp araddr 1", araddr, 32'h10);
    chk("bp arvalid 1", arvalid, 1);
    tick();
    arready = 1'b0;
    chk("bp drained", arvalid, 0);

    // Errors: SLVERR on entry 0, early rlast on entry 1
    r_burst(4'd0, 32'h500, 1, 3, 1'b1, 1'b0);
    r_burst(4'd1, 32'h600, 4, 2, 1'b1, 1'b1);
    chk("err ost_cnt", ost_cnt, 0);
    do_reset();
    chk("err proto cleared", proto_err, 0);
    rvalid = 1'b1;
    rid    = 4'd7;
    rdata  = 32'hDEAD_BEEF;
    rlast  = 1'b1;
    tick();
    rvalid = 1'b0;
    rlast  = 1'b0;
    chk("stray proto_err", proto_err, 1);
    chk("stray done_vld", done_vld, 0);
    chk("stray last_rdata", last_rdata, 32'hDEAD_BEEF);

    // Asynchronous reset with bursts outstanding
    do_reset();
    enable = 1'b1;
    repeat (3) tick();
    enable = 1'b0;
    chk("mid ost_cnt pre", ost_cnt, 3);
    rst = 1'b1;
    #1;
    chk("mid ost_cnt", ost_cnt, 0);
    chk("mid arvalid", arvalid, 0);
    chk("mid full", full, 0);
    chk("mid done_vld", done_vld, 0);
    tick();
    rst    = 1'b0;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    chk("post arvalid", arvalid, 1);
    chk("post arid", arid, 0);
    chk("post araddr", araddr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
